// File: rtl/comp_mult_arbiter.sv
// Shares one comp_mult_wrapper between NO_REQ requesters: round-robin operand grant, in-order tag FIFO for results.
// Optional build macro COMP_MULT_ARB_PRIO_EN gives requester 0 strict priority over the round-robin group.
module comp_mult_arbiter #(
  parameter int DWIDTH    = 8,
  parameter int NO_REQ    = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sw_rst,
  input  logic [NO_REQ-1:0]             req_op_val,
  output logic [NO_REQ-1:0]             req_op_rdy,
  input  logic [NO_REQ*4*DWIDTH-1:0]    req_op_data,
  output logic [NO_REQ-1:0]             req_res_val,
  input  logic [NO_REQ-1:0]             req_res_rdy,
  output logic [4*(DWIDTH+1)-1:0]       req_res_data,
  output logic                          m_op_val,
  input  logic                          m_op_rdy,
  output logic [4*DWIDTH-1:0]           m_op_data,
  input  logic                          m_res_val,
  output logic                          m_res_rdy,
  input  logic [4*(DWIDTH+1)-1:0]       m_res_data
);

  localparam int IDXW = $clog2(NO_REQ);
  localparam int TAGW = $clog2(TAG_DEPTH);
  localparam int OPW  = 4*DWIDTH;
  localparam logic [IDXW-1:0] LAST_REQ = IDXW'(NO_REQ-1);
  localparam logic [TAGW:0]   FULL_CNT = (TAGW+1)'(TAG_DEPTH);

  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0] hold_grant_q, hold_grant_d;
  logic [IDXW-1:0] tag_mem_q [TAG_DEPTH];
  logic [TAGW-1:0] wr_ptr_q, wr_ptr_d;
  logic [TAGW-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAGW:0]   count_q, count_d;
  logic            orphan_err_q, orphan_err_d;

  logic            out_en_s;
  logic            tag_full_s;
  logic            tag_empty_s;
  logic [NO_REQ-1:0] cand_s;
  logic [IDXW-1:0] idx_s;
  logic [IDXW-1:0] arb_grant_s;
  logic [IDXW-1:0] grant_s;
  logic [IDXW-1:0] head_s;
  logic            push_s;
  logic            pop_s;

  // Round-robin search starting one past the pointer; the nearest candidate is written last and wins.
  always_comb begin
    cand_s = req_op_val;
`ifdef COMP_MULT_ARB_PRIO_EN
    cand_s[0] = 1'b0;
`endif
    idx_s       = rr_ptr_q;
    arb_grant_s = rr_ptr_q;
    for (int k = NO_REQ; k >= 1; k--) begin
      idx_s       = IDXW'((int'(rr_ptr_q) + k) % NO_REQ);
      arb_grant_s = cand_s[idx_s] ? idx_s : arb_grant_s;
    end
`ifdef COMP_MULT_ARB_PRIO_EN
    arb_grant_s = req_op_val[0] ? {IDXW{1'b0}} : arb_grant_s;
`endif
  end

  // Operand and result handshakes; every val/rdy output is squashed while either reset is active.
  always_comb begin
    out_en_s    = rst_n & ~sw_rst;
    tag_full_s  = (count_q == FULL_CNT);
    tag_empty_s = (count_q == {(TAGW+1){1'b0}});
    grant_s     = (state_q == HOLD) ? hold_grant_q : arb_grant_s;

    if (state_q == HOLD) begin
      m_op_val = req_op_val[hold_grant_q] & ~tag_full_s & out_en_s;
    end else begin
      m_op_val = (|req_op_val) & ~tag_full_s & out_en_s;
    end
    m_op_data = req_op_data[int'(grant_s)*OPW +: OPW];

    for (int g = 0; g < NO_REQ; g++) begin
      req_op_rdy[g] = m_op_rdy & ~tag_full_s & out_en_s & (grant_s == IDXW'(g));
    end

    head_s = tag_mem_q[rd_ptr_q];
    for (int g = 0; g < NO_REQ; g++) begin
      req_res_val[g] = m_res_val & ~tag_empty_s & out_en_s & (head_s == IDXW'(g));
    end
    m_res_rdy    = ~tag_empty_s & req_res_rdy[head_s] & out_en_s;
    req_res_data = m_res_data;

    push_s = m_op_val & m_op_rdy;
    pop_s  = m_res_val & m_res_rdy;
  end

  // Next-state: grant hold FSM, round-robin pointer, tag FIFO bookkeeping, orphan result flag.
  always_comb begin
    state_d      = state_q;
    hold_grant_d = hold_grant_q;
    case (state_q)
      ARB: begin
        if (m_op_val & ~m_op_rdy) begin
          state_d      = HOLD;
          hold_grant_d = arb_grant_s;
        end else begin
          state_d      = ARB;
        end
      end
      HOLD: begin
        if (m_op_rdy) begin
          state_d = ARB;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase

    if (push_s) begin
      rr_ptr_d = grant_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end

    wr_ptr_d     = wr_ptr_q + TAGW'(push_s);
    rd_ptr_d     = rd_ptr_q + TAGW'(pop_s);
    count_d      = count_q + (TAGW+1)'(push_s) - (TAGW+1)'(pop_s);
    orphan_err_d = orphan_err_q | (m_res_val & tag_empty_s & out_en_s);
  end

  // State registers with async power-on reset and synchronous soft reset that drops in-flight tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      rr_ptr_q     <= LAST_REQ;
      hold_grant_q <= {IDXW{1'b0}};
      wr_ptr_q     <= {TAGW{1'b0}};
      rd_ptr_q     <= {TAGW{1'b0}};
      count_q      <= {(TAGW+1){1'b0}};
      orphan_err_q <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= {IDXW{1'b0}};
      end
    end else if (sw_rst) begin
      state_q      <= ARB;
      rr_ptr_q     <= LAST_REQ;
      hold_grant_q <= {IDXW{1'b0}};
      wr_ptr_q     <= {TAGW{1'b0}};
      rd_ptr_q     <= {TAGW{1'b0}};
      count_q      <= {(TAGW+1){1'b0}};
      orphan_err_q <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= {IDXW{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      hold_grant_q <= hold_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      orphan_err_q <= orphan_err_d;
      if (push_s) begin
        tag_mem_q[wr_ptr_q] <= grant_s;
      end
    end
  end

endmodule
